// File: rtl/spi_reg_pkg.sv
// Shared types and constants for the SPI-to-register bridge.
// SPI_REG_BRIDGE_BURST_EN adds the RD_DATA state used by burst reads.
package spi_reg_pkg;

    localparam int unsigned CMD_RW_BIT      = 7;
    localparam logic [7:0]  IDLE_TX_DEFAULT = 8'h00;

    typedef enum logic [2:0] {
        StCmd,
        StWrData,
        StRdDummy,
`ifdef SPI_REG_BRIDGE_BURST_EN
        StRdData,
`endif
        StDone
    } state_e;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous level.
// RESET_VAL sets both flops so an idle line does not glitch out of reset.
module sync_2ff #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [1:0] sync_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= {2{RESET_VAL}};
        end else begin
            sync_q <= {sync_q[0], d};
        end
    end

    assign q = sync_q[1];

endmodule

// File: rtl/spi_reg_bridge.sv
// Maps framed SPI byte transactions from the slave byte engine onto a register bus.
// Define SPI_REG_BRIDGE_BURST_EN for auto-incrementing burst writes and reads.
module spi_reg_bridge
    import spi_reg_pkg::*;
#(
    parameter int unsigned      ADDR_W  = 7,
    parameter int unsigned      WIDTH   = 8,
    parameter logic [WIDTH-1:0] IDLE_TX = IDLE_TX_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              spi_ss_n,
    input  logic              spi_ready,
    output logic              spi_en,
    input  logic [WIDTH-1:0]  spi_rx_data,
    output logic [WIDTH-1:0]  spi_tx_data,
    output logic [ADDR_W-1:0] reg_addr,
    output logic              reg_wr_en,
    output logic [WIDTH-1:0]  reg_wdata,
    output logic              reg_rd_en,
    input  logic [WIDTH-1:0]  reg_rdata,
    output logic              frame_err
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [WIDTH-1:0]  tx_q, tx_d;
    logic [WIDTH-1:0]  wdata_q, wdata_d;
    logic              wr_en_q, wr_en_d;
    logic              rd_en_q, rd_en_d;
    logic              err_q, err_d;
    logic              en_q;
    logic              hs_q;
    logic              rd_valid_q;
    logic              ss_sync, ss_prev_q;
    logic              active, deselect, hs;

    sync_2ff #(
        .RESET_VAL(1'b1)
    ) u_ss_sync (
        .clk(clk),
        .rst(rst),
        .d  (spi_ss_n),
        .q  (ss_sync)
    );

    assign active   = ~ss_sync;
    assign deselect = ss_sync & ~ss_prev_q;
    assign hs       = en_q & spi_ready;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        tx_d    = tx_q;
        wdata_d = wdata_q;
        wr_en_d = 1'b0;
        rd_en_d = 1'b0;
        err_d   = 1'b0;

        if (hs_q) begin
            tx_d = IDLE_TX;
        end
        // Read data from the bus wins over the post-handshake idle reload.
        if (rd_valid_q) begin
            tx_d = reg_rdata;
        end
`ifdef SPI_REG_BRIDGE_BURST_EN
        // Advance only after the strobe so reg_addr is stable while it is high.
        if (wr_en_q) begin
            addr_d = addr_q + ADDR_W'(1);
        end
`endif

        if (deselect) begin
            state_d = StCmd;
            tx_d    = IDLE_TX;
            err_d   = (state_q == StWrData) || (state_q == StRdDummy);
        end else if (hs) begin
            unique case (state_q)
                StCmd: begin
                    addr_d = spi_rx_data[ADDR_W-1:0];
                    if (spi_rx_data[CMD_RW_BIT]) begin
                        state_d = StWrData;
                    end else begin
                        rd_en_d = 1'b1;
                        state_d = StRdDummy;
                    end
                end
                StWrData: begin
                    wr_en_d = 1'b1;
                    wdata_d = spi_rx_data;
`ifdef SPI_REG_BRIDGE_BURST_EN
                    state_d = StWrData;
`else
                    state_d = StDone;
`endif
                end
                StRdDummy: begin
`ifdef SPI_REG_BRIDGE_BURST_EN
                    addr_d  = addr_q + ADDR_W'(1);
                    rd_en_d = 1'b1;
                    state_d = StRdData;
`else
                    state_d = StDone;
`endif
                end
`ifdef SPI_REG_BRIDGE_BURST_EN
                StRdData: begin
                    addr_d  = addr_q + ADDR_W'(1);
                    rd_en_d = 1'b1;
                end
`endif
                StDone: begin
                    state_d = StDone;
                end
                default: begin
                    state_d = StCmd;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StCmd;
            addr_q     <= '0;
            tx_q       <= IDLE_TX;
            wdata_q    <= '0;
            wr_en_q    <= 1'b0;
            rd_en_q    <= 1'b0;
            err_q      <= 1'b0;
            en_q       <= 1'b0;
            hs_q       <= 1'b0;
            rd_valid_q <= 1'b0;
            ss_prev_q  <= 1'b1;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            tx_q       <= tx_d;
            wdata_q    <= wdata_d;
            wr_en_q    <= wr_en_d;
            rd_en_q    <= rd_en_d;
            err_q      <= err_d;
            en_q       <= spi_ready & ~en_q & active;
            hs_q       <= hs & ~deselect;
            // A read in flight at deselect still runs on the bus; drop its result.
            rd_valid_q <= rd_en_q & ~deselect;
            ss_prev_q  <= ss_sync;
        end
    end

    assign spi_en      = en_q;
    assign spi_tx_data = tx_q;
    assign reg_addr    = addr_q;
    assign reg_wr_en   = wr_en_q;
    assign reg_wdata   = wdata_q;
    assign reg_rd_en   = rd_en_q;
    assign frame_err   = err_q;

endmodule

// File: tb/tb_spi_reg_bridge.sv
// Self-checking bench for spi_reg_bridge: directed vector table, hand sequences and
// random frames against a transaction-level model (honours SPI_REG_BRIDGE_BURST_EN).
module tb_spi_reg_bridge;

    localparam logic [7:0] IDLE = 8'h00;

    logic       clk = 1'b0;
    logic       rst;
    logic       spi_ss_n;
    logic       spi_ready;
    logic       spi_en;
    logic [7:0] spi_rx_data;
    logic [7:0] spi_tx_data;
    logic [6:0] reg_addr;
    logic       reg_wr_en;
    logic [7:0] reg_wdata;
    logic       reg_rd_en;
    logic [7:0] reg_rdata;
    logic       frame_err;

    always #5 clk = ~clk;

    spi_reg_bridge dut (
        .clk        (clk),
        .rst        (rst),
        .spi_ss_n   (spi_ss_n),
        .spi_ready  (spi_ready),
        .spi_en     (spi_en),
        .spi_rx_data(spi_rx_data),
        .spi_tx_data(spi_tx_data),
        .reg_addr   (reg_addr),
        .reg_wr_en  (reg_wr_en),
        .reg_wdata  (reg_wdata),
        .reg_rd_en  (reg_rd_en),
        .reg_rdata  (reg_rdata),
        .frame_err  (frame_err)
    );

    typedef struct packed {
        logic [3:0][7:0] b;
        int              n;
        int              wr_n;
        logic [3:0][6:0] wa;
        logic [3:0][7:0] wd;
        int              rd_n;
        logic [3:0][6:0] ra;
        logic [3:0][7:0] tx;
        int              err;
    } vec_t;

`ifdef SPI_REG_BRIDGE_BURST_EN
    localparam int NV = 4;
`else
    localparam int NV = 5;
`endif
    vec_t vecs[NV];

    int n_vec = 0;
    int n_err = 0;

    // Register file on the bus side; ref_mem is the bench's own expectation.
    logic [7:0] env_mem[128];
    logic [7:0] ref_mem[128];
    logic       load_mem = 1'b0;

    always @(posedge clk) begin
        if (load_mem) begin
            for (int i = 0; i < 128; i++) env_mem[i] <= ref_mem[i];
        end else if (reg_wr_en === 1'b1) begin
            env_mem[reg_addr] <= reg_wdata;
        end
        if (reg_rd_en === 1'b1) reg_rdata <= env_mem[reg_addr];
        else reg_rdata <= 8'($urandom);
    end

    int   wr_log[$];
    int   rd_log[$];
    int   err_cnt = 0;
    int   en_cnt  = 0;
    int   dbl_en  = 0;
    logic en_prev = 1'b0;

    always @(negedge clk) begin
        if (reg_wr_en === 1'b1) wr_log.push_back({17'd0, reg_addr, reg_wdata});
        if (reg_rd_en === 1'b1) rd_log.push_back({25'd0, reg_addr});
        if (frame_err === 1'b1) err_cnt <= err_cnt + 1;
        if (spi_en === 1'b1) en_cnt <= en_cnt + 1;
        if (spi_en === 1'b1 && en_prev) dbl_en <= dbl_en + 1;
        en_prev <= (spi_en === 1'b1);
    end

    int wr_base, rd_base, err_base, en_base, dbl_base;

    logic [7:0] frame_b[8];
    int         frame_n;
    logic [7:0] samp[8];
    int         exp_wr[$];
    int         exp_rd[$];
    logic [7:0] exp_samp[8];
    int         exp_err;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mark();
        wr_base  = wr_log.size();
        rd_base  = rd_log.size();
        err_base = err_cnt;
        en_base  = en_cnt;
        dbl_base = dbl_en;
    endtask

    // Slave side of one byte: offer it, wait for spi_en, grab the byte queued for MISO.
    task automatic send_byte(input logic [7:0] v, output logic [7:0] smp);
        int k = 0;
        spi_rx_data = v;
        spi_ready   = 1'b1;
        while (spi_en !== 1'b1 && k < 20) begin
            tick();
            k++;
        end
        check("hs_wait", int'(spi_en === 1'b1), 1);
        smp = spi_tx_data;
        tick();
        spi_ready   = 1'b0;
        spi_rx_data = 8'($urandom);
        repeat (6) tick();
    endtask

    task automatic do_frame();
        mark();
        spi_ss_n = 1'b0;
        repeat (4) tick();
        for (int i = 0; i < frame_n; i++) send_byte(frame_b[i], samp[i]);
        spi_ss_n = 1'b1;
        repeat (6) tick();
    endtask

    // Transaction-level model: what a frame of bytes should do on the bus and on MISO.
    task automatic compute_expected();
        int   a;
        logic is_wr;
        exp_wr.delete();
        exp_rd.delete();
        for (int i = 0; i < 8; i++) exp_samp[i] = IDLE;
        exp_err = 0;
        if (frame_n == 0) return;
        a     = int'(frame_b[0][6:0]);
        is_wr = frame_b[0][7];
`ifdef SPI_REG_BRIDGE_BURST_EN
        if (is_wr) begin
            for (int i = 1; i < frame_n; i++) begin
                int wa = (a + i - 1) % 128;
                exp_wr.push_back(wa * 256 + int'(frame_b[i]));
                ref_mem[wa] = frame_b[i];
            end
            exp_err = 1;
        end else begin
            for (int i = 0; i < frame_n; i++) exp_rd.push_back((a + i) % 128);
            for (int k = 1; k < frame_n; k++) exp_samp[k] = ref_mem[(a + k - 1) % 128];
            exp_err = (frame_n == 1) ? 1 : 0;
        end
`else
        if (is_wr) begin
            if (frame_n >= 2) begin
                exp_wr.push_back(a * 256 + int'(frame_b[1]));
                ref_mem[a] = frame_b[1];
            end
        end else begin
            exp_rd.push_back(a);
            if (frame_n >= 2) exp_samp[1] = ref_mem[a];
        end
        exp_err = (frame_n == 1) ? 1 : 0;
`endif
    endtask

    task automatic check_frame();
        check("wr_count", wr_log.size() - wr_base, exp_wr.size());
        for (int i = 0; i < exp_wr.size() && wr_base + i < wr_log.size(); i++)
            check("wr_addr_data", wr_log[wr_base + i], exp_wr[i]);
        check("rd_count", rd_log.size() - rd_base, exp_rd.size());
        for (int i = 0; i < exp_rd.size() && rd_base + i < rd_log.size(); i++)
            check("rd_addr", rd_log[rd_base + i], exp_rd[i]);
        for (int i = 0; i < frame_n; i++) check("miso_byte", int'(samp[i]), int'(exp_samp[i]));
        check("frame_err", err_cnt - err_base, exp_err);
        check("en_pulses", en_cnt - en_base, frame_n);
        check("en_back_to_back", dbl_en - dbl_base, 0);
    endtask

    task automatic check_reset_outs(input string tag);
        check({tag, "_spi_en"}, int'(spi_en), 0);
        check({tag, "_tx"}, int'(spi_tx_data), int'(IDLE));
        check({tag, "_addr"}, int'(reg_addr), 0);
        check({tag, "_wr_en"}, int'(reg_wr_en), 0);
        check({tag, "_wdata"}, int'(reg_wdata), 0);
        check({tag, "_rd_en"}, int'(reg_rd_en), 0);
        check({tag, "_frame_err"}, int'(frame_err), 0);
    endtask

    initial begin
        rst         = 1'b1;
        spi_ss_n    = 1'b1;
        spi_ready   = 1'b0;
        spi_rx_data = 8'h00;
        for (int i = 0; i < 128; i++) ref_mem[i] = 8'($urandom);
        ref_mem[7'h12] = 8'hA7;
        ref_mem[7'h01] = 8'h5A;
        load_mem = 1'b1;
        tick();
        tick();
        load_mem = 1'b0;
        tick();
        check_reset_outs("reset");
        rst = 1'b0;
        repeat (2) tick();

`ifdef SPI_REG_BRIDGE_BURST_EN
        vecs[0] = '{b: {8'hCC, 8'hBB, 8'hAA, 8'hFE}, n: 4, wr_n: 3,
                    wa: {7'h00, 7'h00, 7'h7F, 7'h7E}, wd: {8'h00, 8'hCC, 8'hBB, 8'hAA},
                    rd_n: 0, ra: '0, tx: '0, err: 1};
        vecs[1] = '{b: {8'h00, 8'h00, 8'h00, 8'h7F}, n: 4, wr_n: 0, wa: '0, wd: '0,
                    rd_n: 4, ra: {7'h02, 7'h01, 7'h00, 7'h7F},
                    tx: {8'h5A, 8'hCC, 8'hBB, 8'h00}, err: 0};
        vecs[2] = '{b: {8'h00, 8'h00, 8'h00, 8'h90}, n: 1, wr_n: 0, wa: '0, wd: '0,
                    rd_n: 0, ra: '0, tx: '0, err: 1};
        vecs[3] = '{b: {8'h00, 8'h00, 8'h00, 8'h12}, n: 1, wr_n: 0, wa: '0, wd: '0,
                    rd_n: 1, ra: {7'h00, 7'h00, 7'h00, 7'h12}, tx: '0, err: 1};
`else
        vecs[0] = '{b: {8'h00, 8'h00, 8'h3C, 8'h85}, n: 2, wr_n: 1,
                    wa: {7'h00, 7'h00, 7'h00, 7'h05}, wd: {8'h00, 8'h00, 8'h00, 8'h3C},
                    rd_n: 0, ra: '0, tx: '0, err: 0};
        vecs[1] = '{b: {8'h00, 8'h00, 8'h00, 8'h12}, n: 3, wr_n: 0, wa: '0, wd: '0,
                    rd_n: 1, ra: {7'h00, 7'h00, 7'h00, 7'h12},
                    tx: {8'h00, 8'h00, 8'hA7, 8'h00}, err: 0};
        vecs[2] = '{b: {8'h00, 8'h00, 8'h00, 8'h90}, n: 1, wr_n: 0, wa: '0, wd: '0,
                    rd_n: 0, ra: '0, tx: '0, err: 1};
        vecs[3] = '{b: {8'h33, 8'h22, 8'h11, 8'h81}, n: 4, wr_n: 1,
                    wa: {7'h00, 7'h00, 7'h00, 7'h01}, wd: {8'h00, 8'h00, 8'h00, 8'h11},
                    rd_n: 0, ra: '0, tx: '0, err: 0};
        vecs[4] = '{b: {8'h00, 8'h00, 8'h00, 8'h05}, n: 1, wr_n: 0, wa: '0, wd: '0,
                    rd_n: 1, ra: {7'h00, 7'h00, 7'h00, 7'h05}, tx: '0, err: 1};
`endif

        for (int v = 0; v < NV; v++) begin
            frame_n = vecs[v].n;
            for (int i = 0; i < 4; i++) frame_b[i] = vecs[v].b[i];
            exp_wr.delete();
            exp_rd.delete();
            for (int i = 0; i < vecs[v].wr_n; i++) begin
                exp_wr.push_back(int'(vecs[v].wa[i]) * 256 + int'(vecs[v].wd[i]));
                ref_mem[vecs[v].wa[i]] = vecs[v].wd[i];
            end
            for (int i = 0; i < vecs[v].rd_n; i++) exp_rd.push_back(int'(vecs[v].ra[i]));
            for (int i = 0; i < 8; i++) exp_samp[i] = (i < 4) ? vecs[v].tx[i] : IDLE;
            exp_err = vecs[v].err;
            do_frame();
            check_frame();
        end

        // A byte offered while deselected stays pending until the frame opens.
        frame_n    = 2;
        frame_b[0] = 8'h81;
        frame_b[1] = 8'h11;
        compute_expected();
        mark();
        spi_ss_n    = 1'b1;
        spi_rx_data = 8'h81;
        spi_ready   = 1'b1;
        repeat (10) tick();
        check("en_while_inactive", en_cnt - en_base, 0);
        spi_ss_n = 1'b0;
        for (int k = 0; k < 20 && spi_en !== 1'b1; k++) tick();
        check("pending_byte_hs", int'(spi_en === 1'b1), 1);
        samp[0] = spi_tx_data;
        tick();
        spi_ready = 1'b0;
        repeat (6) tick();
        send_byte(8'h11, samp[1]);
        spi_ss_n = 1'b1;
        repeat (6) tick();
        check_frame();

        // Reset while waiting for the dummy byte of a read.
        mark();
        spi_ss_n = 1'b0;
        repeat (4) tick();
        send_byte(8'h12, samp[0]);
        check("rd_result_loaded", int'(spi_tx_data), int'(ref_mem[7'h12]));
        rst = 1'b1;
        tick();
        check_reset_outs("rst_mid_frame");
        rst = 1'b0;
        repeat (2) tick();
        spi_ss_n = 1'b1;
        repeat (6) tick();
        check("rst_no_frame_err", err_cnt - err_base, 0);
        check("rst_no_write", wr_log.size() - wr_base, 0);
        check("rst_read_count", rd_log.size() - rd_base, 1);

        for (int f = 0; f < 40; f++) begin
            frame_n = int'($urandom_range(0, 5));
            for (int i = 0; i < 8; i++) frame_b[i] = 8'($urandom);
            compute_expected();
            do_frame();
            check_frame();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
